ahb_bridge_arbiter: RTL and testbench
=====================================

Name: ahb_bridge_arbiter

Overview:
- Round-robin arbiter and transfer sequencer that shares the AHB2APB bridge's AHB slave port between NUM_MASTERS simple request/ack clients.
- Converts each granted request into one AHB-lite single transfer: a NONSEQ address phase followed by a data phase.
- Waits on bridge Hreadyout, returns read data and error status, then re-arbitrates.
- Sits directly in front of Bridge_Top; drives its Haddr/Hwrite/Htrans/Hwdata/Hreadyin.

Parameters:
- NUM_MASTERS, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, data-phase wait limit; used only with ARB_TIMEOUT_EN.

Ports:
- Hclk  input  1  clock; all logic on rising edge.
- Hreset  input  1  asynchronous, active-high reset.
- req  input  NUM_MASTERS  per-master request; held high until that master's ack.
- m_addr  input  32*NUM_MASTERS  per-master address; master i uses bits [32i+31:32i].
- m_write  input  NUM_MASTERS  per-master direction: 1 = write.
- m_wdata  input  32*NUM_MASTERS  per-master write data.
- grant  output  NUM_MASTERS  one-hot owner of the current transfer; 0 when idle.
- ack  output  NUM_MASTERS  one-cycle completion pulse to the owner.
- err  output  NUM_MASTERS  one-cycle pulse, coincident with ack, when the transfer failed.
- m_rdata  output  32  read data, valid in the ack cycle.
- busy  output  1  high in ADDR or DATA.
- Haddr  output  32  to bridge.
- Hwrite  output  1  to bridge.
- Htrans  output  2  to bridge: 2'b00 IDLE, 2'b10 NONSEQ.
- Hwdata  output  32  to bridge.
- Hreadyin  output  1  to bridge.
- Hreadyout  input  1  from bridge.
- Hresp  input  2  from bridge.
- Hrdata  input  32  from bridge.

Behaviour:
- Reset (async, Hreset=1) puts the block in state IDLE and clears:
  - all outputs to 0, except Hreadyin=1;
  - round-robin pointer last = NUM_MASTERS-1, so master 0 wins first.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any req: pick the first requesting index searching from last+1 upward with wrap.
  - Register grant one-hot; latch that master's addr, write and wdata into internal regs; last <= winner; go to ADDR.
  - Otherwise stay in IDLE.
- ADDR (exactly 1 cycle):
  - Htrans=2'b10, Haddr/Hwrite = latched values, Hreadyin=1.
  - Go to DATA.
- DATA:
  - Htrans=2'b00; Haddr and Hwrite hold their values.
  - Hwdata = latched wdata, driven for writes and reads alike.
  - Hreadyin = Hreadyout.
  - On Hreadyout=1:
    - ack[owner]=1 for one cycle;
    - m_rdata <= Hrdata if read, else held;
    - err[owner]=1 if Hresp != 2'b00;
    - grant cleared; go to IDLE.
  - On Hreadyout=0: stay in DATA.
- Minimum transfer length is 3 cycles from grant to IDLE: IDLE -> ADDR -> DATA with zero wait states. No back-to-back pipelining.
- grant is stable from grant cycle through the ack cycle.
- req changes from non-owners mid-transfer are ignored until the next IDLE.
- A master whose req drops before ack still completes its transfer; the ack is still issued.
- Simultaneous requests are served strictly round-robin. A continuously requesting master waits at most NUM_MASTERS-1 transfers.
- Reset mid-transfer:
  - immediate return to IDLE, outputs to reset values;
  - no ack is issued for the in-flight transfer;
  - the bridge sees Htrans=IDLE.
- Single master only, all req=0: busy stays 0, and Htrans stays IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to DATA and increments on each DATA cycle with Hreadyout=0.
  - When it reaches TIMEOUT_CYCLES: ack[owner]=1 and err[owner]=1 together, m_rdata unchanged, go to IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined:
  - no counter; DATA waits indefinitely for Hreadyout.

Test Plan:
- Master 0 write, addr=0x8000_0010, wdata=0xDEAD_BEEF, Hreadyout=1 -> Htrans=2'b10 one cycle with Haddr=0x8000_0010, Hwrite=1; next cycle Hwdata=0xDEAD_BEEF; ack[0] pulses in the cycle after ADDR; err=0.
- req=3'b111 held continuously -> grants in order 001, 010, 100, 001; each ack one-hot matches grant.
- Master 1 read, addr=0x8400_0004, bridge holds Hreadyout=0 for 2 cycles then 1 with Hrdata=0x1234_5678 -> ack[1] after 2 wait cycles; m_rdata=0x1234_5678; Hreadyin tracks Hreadyout.
- Master 2 write, Hresp=2'b01 at completion -> ack[2]=1 and err[2]=1 in the same cycle; next grant goes to master 0 if requesting.
- Hreset asserted during DATA -> next edge: grant=0, busy=0, Htrans=2'b00, Hreadyin=1, no ack; after release, master 0 is served first.
- ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, Hreadyout stuck 0 -> ack and err of the owner pulse after 4 wait cycles; FSM returns to IDLE.

Source files
------------

// File: rtl/ahb_bridge_arbiter_if.sv
// Bundle between the request/ack clients, the arbiter and the AHB2APB bridge slave port.
// The "master" modport is the arbiter's view: it masters the bridge and answers the clients.
// The "slave" modport is the environment's view: the clients plus the bridge.
interface ahb_bridge_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 3
);
  // client side
  logic [NUM_MASTERS-1:0]    req;
  logic [32*NUM_MASTERS-1:0] m_addr;
  logic [NUM_MASTERS-1:0]    m_write;
  logic [32*NUM_MASTERS-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]    grant;
  logic [NUM_MASTERS-1:0]    ack;
  logic [NUM_MASTERS-1:0]    err;
  logic [31:0]               m_rdata;
  logic                      busy;
  // bridge side
  logic [31:0]               Haddr;
  logic                      Hwrite;
  logic [1:0]                Htrans;
  logic [31:0]               Hwdata;
  logic                      Hreadyin;
  logic                      Hreadyout;
  logic [1:0]                Hresp;
  logic [31:0]               Hrdata;

  modport master (
    input  req, m_addr, m_write, m_wdata, Hreadyout, Hresp, Hrdata,
    output grant, ack, err, m_rdata, busy, Haddr, Hwrite, Htrans, Hwdata, Hreadyin
  );

  modport slave (
    output req, m_addr, m_write, m_wdata, Hreadyout, Hresp, Hrdata,
    input  grant, ack, err, m_rdata, busy, Haddr, Hwrite, Htrans, Hwdata, Hreadyin
  );
endinterface

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter that turns client requests into single AHB-lite NONSEQ transfers
// towards the AHB2APB bridge. Optional data-phase watchdog enabled by ARB_TIMEOUT_EN.
module ahb_bridge_arbiter #(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                  Hclk,
  input logic                  Hreset,
  ahb_bridge_arbiter_if.master bus
);

  localparam int unsigned IdxW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IdxW-1:0]        last_q;
  logic [IdxW-1:0]        winner;
  logic [31:0]            addr_q, wdata_q, rdata_q;
  logic                   write_q;
  logic [31:0]            sel_addr, sel_wdata;
  logic                   sel_write;
  logic                   any_req;
  logic                   done;
  logic                   fail;
  logic                   rd_capture;
  logic [1:0]             htrans;
  logic                   hreadyin;
  logic                   busy;
  logic                   tmo_hit;

  // First requester found searching upward from last+1 with wrap.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                              input logic [IdxW-1:0]        last);
    logic [IdxW-1:0] pick;
    int unsigned     cand;
    pick = last;
    // Descending scan so the nearest candidate after 'last' is written last.
    for (int unsigned k = NUM_MASTERS; k >= 1; k--) begin
      cand = (32'(last) + k) % NUM_MASTERS;
      if (r[IdxW'(cand)]) pick = IdxW'(cand);
    end
    return pick;
  endfunction

  assign any_req = |bus.req;
  assign winner  = rr_pick(bus.req, last_q);

  // Select the winning master's transfer attributes.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (winner == IdxW'(i)) begin
        sel_addr  = bus.m_addr[32*i +: 32];
        sel_wdata = bus.m_wdata[32*i +: 32];
        sel_write = bus.m_write[i];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_q;

  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYCLES));

  // Count data-phase wait cycles; restarts every time a new data phase begins.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      tmo_q <= '0;
    end else if (state_q == StAddr) begin
      tmo_q <= '0;
    end else if (state_q == StData && !bus.Hreadyout && !tmo_hit) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  // No watchdog: the data phase waits for Hreadyout indefinitely.
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (any_req) state_d = StAddr;
      StAddr:  state_d = StData;
      StData:  if (done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and completion decode.
  always_comb begin
    htrans     = 2'b00;
    hreadyin   = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    fail       = 1'b0;
    rd_capture = 1'b0;
    case (state_q)
      StAddr: begin
        htrans = 2'b10;
        busy   = 1'b1;
      end
      StData: begin
        busy     = 1'b1;
        hreadyin = bus.Hreadyout;
        if (bus.Hreadyout) begin
          done       = 1'b1;
          fail       = (bus.Hresp != 2'b00);
          rd_capture = !write_q;
        end else if (tmo_hit) begin
          done = 1'b1;
          fail = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Grant, round-robin pointer, latched transfer and captured read data.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      grant_q <= '0;
      last_q  <= IdxW'(NUM_MASTERS - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state_q == StIdle && any_req) begin
        grant_q <= NUM_MASTERS'(1) << winner;
        last_q  <= winner;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        write_q <= sel_write;
      end else if (done) begin
        grant_q <= '0;
      end
      if (rd_capture) begin
        rdata_q <= bus.Hrdata;
      end
    end
  end

  assign bus.grant    = grant_q;
  assign bus.ack      = done ? grant_q : '0;
  assign bus.err      = (done && fail) ? grant_q : '0;
  // Read data is forwarded in the ack cycle and held from the register afterwards.
  assign bus.m_rdata  = rd_capture ? bus.Hrdata : rdata_q;
  assign bus.busy     = busy;
  assign bus.Haddr    = addr_q;
  assign bus.Hwrite   = write_q;
  assign bus.Htrans   = htrans;
  assign bus.Hwdata   = (state_q == StData) ? wdata_q : '0;
  assign bus.Hreadyin = hreadyin;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed bench for ahb_bridge_arbiter (3 masters, TIMEOUT_CYCLES=4).
module tb_ahb_bridge_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  ahb_bridge_arbiter_if #(.NUM_MASTERS(3)) bus ();

  ahb_bridge_arbiter #(
    .NUM_MASTERS(3),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .Hclk  (clk),
    .Hreset(rst),
    .bus   (bus)
  );

  // Advance one clock; returns 2ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step();
    #1;
    checks++; if (bus.grant !== 3'b000) $display("FAIL rst_grant got=%b want=000", bus.grant); else passed++;
    checks++; if (bus.ack !== 3'b000 || bus.err !== 3'b000) $display("FAIL rst_ackerr got=%b/%b want=000/000", bus.ack, bus.err); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", bus.busy); else passed++;
    checks++; if (bus.Htrans !== 2'b00) $display("FAIL rst_htrans got=%b want=00", bus.Htrans); else passed++;
    checks++; if (bus.Hreadyin !== 1'b1) $display("FAIL rst_hreadyin got=%b want=1", bus.Hreadyin); else passed++;
    checks++; if (bus.m_rdata !== 32'h0 || bus.Haddr !== 32'h0) $display("FAIL rst_data got=%h/%h want=0/0", bus.m_rdata, bus.Haddr); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    bus.Hreadyout = 1'b1;
    bus.Hresp     = 2'b00;
    bus.m_addr    = '0;
    bus.m_wdata   = '0;
    bus.m_addr[31:0]  = 32'h8000_0010;
    bus.m_wdata[31:0] = 32'hDEAD_BEEF;
    bus.m_write   = 3'b001;
    bus.req       = 3'b001;
    step();
    #1;
    checks++; if (bus.Htrans !== 2'b10) $display("FAIL wr_addr_htrans got=%b want=10", bus.Htrans); else passed++;
    checks++; if (bus.Haddr !== 32'h8000_0010 || bus.Hwrite !== 1'b1) $display("FAIL wr_addr_phase got=%h/%b want=80000010/1", bus.Haddr, bus.Hwrite); else passed++;
    checks++; if (bus.grant !== 3'b001 || bus.busy !== 1'b1 || bus.ack !== 3'b000) $display("FAIL wr_addr_ctl got=%b/%b/%b want=001/1/000", bus.grant, bus.busy, bus.ack); else passed++;
    step();
    #1;
    checks++; if (bus.Htrans !== 2'b00) $display("FAIL wr_data_htrans got=%b want=00", bus.Htrans); else passed++;
    checks++; if (bus.Hwdata !== 32'hDEAD_BEEF) $display("FAIL wr_hwdata got=%h want=deadbeef", bus.Hwdata); else passed++;
    checks++; if (bus.ack !== 3'b001 || bus.err !== 3'b000) $display("FAIL wr_ack got=%b/%b want=001/000", bus.ack, bus.err); else passed++;
    checks++; if (bus.grant !== 3'b001) $display("FAIL wr_grant_hold got=%b want=001", bus.grant); else passed++;
    bus.req = 3'b000;
    step();
    #1;
    checks++; if (bus.grant !== 3'b000 || bus.busy !== 1'b0 || bus.ack !== 3'b000) $display("FAIL wr_idle got=%b/%b/%b want=000/0/000", bus.grant, bus.busy, bus.ack); else passed++;
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_g [4];
    logic [31:0] exp_a [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_a = '{32'h100, 32'h200, 32'h300, 32'h100};
    do_reset();
    bus.m_addr  = {32'h300, 32'h200, 32'h100};
    bus.m_write = 3'b111;
    bus.Hreadyout = 1'b1;
    bus.req     = 3'b111;
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      checks++; if (bus.grant !== exp_g[k] || bus.Haddr !== exp_a[k]) $display("FAIL rr_grant%0d got=%b/%h want=%b/%h", k, bus.grant, bus.Haddr, exp_g[k], exp_a[k]); else passed++;
      step();
      #1;
      checks++; if (bus.ack !== exp_g[k]) $display("FAIL rr_ack%0d got=%b want=%b", k, bus.ack, exp_g[k]); else passed++;
      step();
    end
    bus.req = 3'b000;
    step();
  endtask

  task automatic test_read_wait();
    // last winner was master 0
    bus.m_addr[63:32] = 32'h8400_0004;
    bus.m_write   = 3'b000;
    bus.Hreadyout = 1'b0;
    bus.Hrdata    = 32'h0BAD_0BAD;
    bus.req       = 3'b010;
    step();
    #1;
    checks++; if (bus.grant !== 3'b010 || bus.Haddr !== 32'h8400_0004 || bus.Hwrite !== 1'b0) $display("FAIL rd_addr got=%b/%h/%b want=010/84000004/0", bus.grant, bus.Haddr, bus.Hwrite); else passed++;
    for (int w = 0; w < 2; w++) begin
      step();
      #1;
      checks++; if (bus.ack !== 3'b000 || bus.Hreadyin !== 1'b0) $display("FAIL rd_wait%0d got=%b/%b want=000/0", w, bus.ack, bus.Hreadyin); else passed++;
    end
    bus.Hreadyout = 1'b1;
    bus.Hrdata    = 32'h1234_5678;
    #1;
    checks++; if (bus.ack !== 3'b010 || bus.err !== 3'b000 || bus.Hreadyin !== 1'b1) $display("FAIL rd_ack got=%b/%b/%b want=010/000/1", bus.ack, bus.err, bus.Hreadyin); else passed++;
    checks++; if (bus.m_rdata !== 32'h1234_5678) $display("FAIL rd_data got=%h want=12345678", bus.m_rdata); else passed++;
    bus.req = 3'b000;
    step();
    bus.Hrdata = 32'hFFFF_0000;
    #1;
    checks++; if (bus.m_rdata !== 32'h1234_5678 || bus.busy !== 1'b0) $display("FAIL rd_hold got=%h/%b want=12345678/0", bus.m_rdata, bus.busy); else passed++;
  endtask

  task automatic test_error();
    // last winner was master 1, so master 2 beats master 0
    bus.m_write   = 3'b101;
    bus.Hreadyout = 1'b1;
    bus.Hresp     = 2'b01;
    bus.req       = 3'b101;
    step();
    #1;
    checks++; if (bus.grant !== 3'b100) $display("FAIL err_grant got=%b want=100", bus.grant); else passed++;
    step();
    #1;
    checks++; if (bus.ack !== 3'b100 || bus.err !== 3'b100) $display("FAIL err_pulse got=%b/%b want=100/100", bus.ack, bus.err); else passed++;
    bus.req = 3'b001;
    step();
    bus.Hresp = 2'b00;
    step();
    #1;
    checks++; if (bus.grant !== 3'b001) $display("FAIL err_next_grant got=%b want=001", bus.grant); else passed++;
    step();
    #1;
    checks++; if (bus.ack !== 3'b001 || bus.err !== 3'b000) $display("FAIL err_next_ack got=%b/%b want=001/000", bus.ack, bus.err); else passed++;
    bus.req = 3'b000;
    step();
  endtask

  task automatic test_reset_mid();
    // last winner was master 0, so master 1 is taken
    bus.Hreadyout = 1'b0;
    bus.req       = 3'b010;
    step();
    step();
    #1;
    checks++; if (bus.grant !== 3'b010 || bus.busy !== 1'b1) $display("FAIL rm_pre got=%b/%b want=010/1", bus.grant, bus.busy); else passed++;
    rst = 1'b1;
    bus.Hreadyout = 1'b1;
    step();
    #1;
    checks++; if (bus.grant !== 3'b000 || bus.busy !== 1'b0 || bus.ack !== 3'b000) $display("FAIL rm_clear got=%b/%b/%b want=000/0/000", bus.grant, bus.busy, bus.ack); else passed++;
    checks++; if (bus.Htrans !== 2'b00 || bus.Hreadyin !== 1'b1) $display("FAIL rm_bus got=%b/%b want=00/1", bus.Htrans, bus.Hreadyin); else passed++;
    bus.req = 3'b011;
    rst = 1'b0;
    step();
    #1;
    checks++; if (bus.grant !== 3'b001) $display("FAIL rm_first got=%b want=001", bus.grant); else passed++;
    step();
    bus.req = 3'b000;
    step();
  endtask

  task automatic test_idle();
    bus.req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.Htrans !== 2'b00) $display("FAIL idle%0d got=%b/%b want=0/00", i, bus.busy, bus.Htrans); else passed++;
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    // reset above cleared the held read data
    bus.m_write   = 3'b000;
    bus.Hreadyout = 1'b0;
    bus.Hrdata    = 32'hAAAA_5555;
    bus.req       = 3'b100;
    step();
    for (int w = 0; w < 4; w++) begin
      step();
      #1;
      checks++; if (bus.ack !== 3'b000) $display("FAIL tmo_wait%0d got=%b want=000", w, bus.ack); else passed++;
    end
    step();
    #1;
    checks++; if (bus.ack !== 3'b100 || bus.err !== 3'b100) $display("FAIL tmo_pulse got=%b/%b want=100/100", bus.ack, bus.err); else passed++;
    checks++; if (bus.m_rdata !== 32'h0) $display("FAIL tmo_rdata got=%h want=0", bus.m_rdata); else passed++;
    bus.req = 3'b000;
    step();
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.grant !== 3'b000) $display("FAIL tmo_idle got=%b/%b want=0/000", bus.busy, bus.grant); else passed++;
  endtask
`endif

  initial begin
    bus.req       = '0;
    bus.m_addr    = '0;
    bus.m_write   = '0;
    bus.m_wdata   = '0;
    bus.Hreadyout = 1'b1;
    bus.Hresp     = 2'b00;
    bus.Hrdata    = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_wait();
    test_error();
    test_reset_mid();
    test_idle();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
